s0_rs_enc: RTL and testbench



---
 rtl/s0_rs_enc_if.sv | 24 ++
 rtl/s0_rs_enc.sv | 180 ++++++++++++++++++
 tb/tb_s0_rs_enc.sv | 330 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/s0_rs_enc_if.sv
// Byte-stream bundle for the RS(K+4,K) encoder: message bytes in, codeword bytes out.
// A byte moves on a channel in any cycle where its vld and rdy are both high; a producer
// holding vld keeps its data/sop/eop stable until the consumer raises rdy.
interface s0_rs_enc_if;
    logic [7:0] in_data;
    logic       in_vld;
    logic       in_rdy;
    logic       in_eop;
    logic [7:0] enc_data;
    logic       enc_vld;
    logic       enc_sop;
    logic       enc_eop;
    logic       enc_rdy;

    modport master (
        output in_data, in_vld, in_eop, enc_rdy,
        input  in_rdy, enc_data, enc_vld, enc_sop, enc_eop
    );

    modport slave (
        input  in_data, in_vld, in_eop, enc_rdy,
        output in_rdy, enc_data, enc_vld, enc_sop, enc_eop
    );
endinterface

// File: rtl/s0_rs_enc.sv
// Byte-serial systematic RS encoder over GF(2^8)/0x11D, 4 parity bytes, g(x) roots alpha^0..alpha^3.
// Optional macro RS_ENC_SHORT_EN: in_eop on an accepted byte ends a shortened message early.
module gf2m8_multi (
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] p
);
    logic [7:0] acc;
    logic [7:0] sh;

    always_comb begin
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1D : 8'h00);
        end
        p = acc;
    end
endmodule

module s0_rs_enc #(
    parameter int K  = 251,
    parameter int CW = 8
) (
    input  logic        clk,
    input  logic        rstn,
    s0_rs_enc_if.slave  bus,
    output logic [2:0]  dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        DATA = 3'b010,
        PAR  = 3'b100
    } state_t;

    localparam logic [CW-1:0] K_CNT = CW'(K);

    state_t        state_q, state_d;
    logic [7:0]    p0_q, p1_q, p2_q, p3_q;
    logic [7:0]    p0_d, p1_d, p2_d, p3_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    pidx_q, pidx_d;
    logic [7:0]    data_q, data_d;
    logic          vld_q, vld_d;
    logic          sop_q, sop_d;
    logic          eop_q, eop_d;

    logic          adv;
    logic          in_rdy_c;
    logic          last_in;
    logic [7:0]    fb;
    logic [7:0]    m0, m1, m2, m3;

`ifdef RS_ENC_SHORT_EN
    assign last_in = bus.in_eop;
`else
    logic unused_eop;
    assign unused_eop = bus.in_eop;
    assign last_in    = 1'b0;
`endif

    // The first byte of a frame starts from cleared parity, so the old p3 is not fed back.
    assign fb = bus.in_data ^ ((state_q == DATA) ? p3_q : 8'h00);

    gf2m8_multi u_mul3 (.a(fb), .b(8'h0F), .p(m3));
    gf2m8_multi u_mul2 (.a(fb), .b(8'h36), .p(m2));
    gf2m8_multi u_mul1 (.a(fb), .b(8'h78), .p(m1));
    gf2m8_multi u_mul0 (.a(fb), .b(8'h40), .p(m0));

    always_comb begin
        adv      = !vld_q || bus.enc_rdy;
        in_rdy_c = 1'b0;
        state_d  = state_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        p3_d     = p3_q;
        cnt_d    = cnt_q;
        pidx_d   = pidx_q;
        data_d   = data_q;
        vld_d    = vld_q;
        sop_d    = sop_q;
        eop_d    = eop_q;

        case (state_q)
            IDLE: begin
                in_rdy_c = adv;
                if (adv) begin
                    vld_d = 1'b0;
                    sop_d = 1'b0;
                    eop_d = 1'b0;
                    if (bus.in_vld) begin
                        p3_d    = m3;
                        p2_d    = m2;
                        p1_d    = m1;
                        p0_d    = m0;
                        data_d  = bus.in_data;
                        vld_d   = 1'b1;
                        sop_d   = 1'b1;
                        cnt_d   = CW'(1);
                        pidx_d  = 2'd0;
                        state_d = (K == 1 || last_in) ? PAR : DATA;
                    end
                end
            end
            DATA: begin
                in_rdy_c = adv;
                if (adv) begin
                    vld_d = 1'b0;
                    sop_d = 1'b0;
                    eop_d = 1'b0;
                    if (bus.in_vld) begin
                        p3_d   = p2_q ^ m3;
                        p2_d   = p1_q ^ m2;
                        p1_d   = p0_q ^ m1;
                        p0_d   = m0;
                        data_d = bus.in_data;
                        vld_d  = 1'b1;
                        cnt_d  = cnt_q + CW'(1);
                        if ((cnt_q + CW'(1)) == K_CNT || last_in) begin
                            state_d = PAR;
                            pidx_d  = 2'd0;
                        end
                    end
                end
            end
            PAR: begin
                if (adv) begin
                    data_d = p3_q;
                    vld_d  = 1'b1;
                    sop_d  = 1'b0;
                    eop_d  = (pidx_q == 2'd3);
                    p3_d   = p2_q;
                    p2_d   = p1_q;
                    p1_d   = p0_q;
                    p0_d   = 8'h00;
                    pidx_d = pidx_q + 2'd1;
                    if (pidx_q == 2'd3) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            p0_q    <= 8'h00;
            p1_q    <= 8'h00;
            p2_q    <= 8'h00;
            p3_q    <= 8'h00;
            cnt_q   <= '0;
            pidx_q  <= 2'd0;
            data_q  <= 8'h00;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
            p3_q    <= p3_d;
            cnt_q   <= cnt_d;
            pidx_q  <= pidx_d;
            data_q  <= data_d;
            vld_q   <= vld_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    assign bus.in_rdy   = in_rdy_c;
    assign bus.enc_data = data_q;
    assign bus.enc_vld  = vld_q;
    assign bus.enc_sop  = sop_q;
    assign bus.enc_eop  = eop_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_s0_rs_enc.sv
// Bench for s0_rs_enc: K=1 and K=251 encoders checked against a polynomial long-division model
// and syndrome evaluation at alpha^0..alpha^3. Honours RS_ENC_SHORT_EN when defined.
module tb_s0_rs_enc;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int   cyc  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    s0_rs_enc_if b1 ();
    s0_rs_enc_if b2 ();
    logic [2:0] dbg1, dbg2;

    s0_rs_enc #(.K(1), .CW(8)) u_k1 (
        .clk(clk), .rstn(rstn), .bus(b1), .dbg_state(dbg1)
    );
    s0_rs_enc #(.K(251), .CW(8)) u_k251 (
        .clk(clk), .rstn(rstn), .bus(b2), .dbg_state(dbg2)
    );

    int         n_asserts = 0;
    int         n_fail    = 0;
    logic [7:0] msg [0:511];
    logic [9:0] exp_q1 [$];
    logic [9:0] exp_q2 [$];
    logic [7:0] got1 [$];
    logic [7:0] got2 [$];
    int         n_out [2];
    int         first_c [2];
    int         last_c [2];
    int         sop_n [2];
    int         eop_n [2];
    bit         prev_stall [2];
    logic [7:0] prev_d [2];
    bit         stall [2];
    logic [7:0] g_d [0:4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_asserts++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // ---------------- GF(2^8) reference arithmetic ----------------
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) acc = acc ^ (16'(a) << i);
        for (int i = 15; i >= 8; i--) if (acc[i]) acc = acc ^ (16'h011D << (i - 8));
        return acc[7:0];
    endfunction

    function automatic logic [7:0] gf_pow(input int r);
        logic [7:0] p;
        p = 8'h01;
        for (int i = 0; i < r; i++) p = gf_mul(p, 8'h02);
        return p;
    endfunction

    // g(x) built as the product of (x + alpha^r); g_d[0] is the x^4 coefficient.
    task automatic make_gen();
        logic [7:0] c [0:4];
        c[0] = 8'h01;
        for (int j = 1; j < 5; j++) c[j] = 8'h00;
        for (int r = 0; r < 4; r++) begin
            for (int j = 4; j >= 1; j--) c[j] = c[j-1] ^ gf_mul(c[j], gf_pow(r));
            c[0] = gf_mul(c[0], gf_pow(r));
        end
        for (int j = 0; j < 5; j++) g_d[j] = c[4-j];
    endtask

    // Codeword = message, then remainder of m(x)*x^4 divided by g(x).
    task automatic push_cw(input int sel, input int off, input int n);
        logic [7:0] a [0:259];
        logic [7:0] coef;
        logic [9:0] e;
        for (int i = 0; i < n; i++) a[i] = msg[off+i];
        for (int i = n; i < n + 4; i++) a[i] = 8'h00;
        for (int i = 0; i < n; i++) begin
            coef = a[i];
            for (int j = 0; j < 5; j++) a[i+j] = a[i+j] ^ gf_mul(coef, g_d[j]);
        end
        for (int i = 0; i < n + 4; i++) begin
            e = {(i == 0), (i == n + 3), (i < n) ? msg[off+i] : a[i]};
            if (sel == 0) exp_q1.push_back(e);
            else          exp_q2.push_back(e);
        end
    endtask

    task automatic check_syn(input string tag);
        logic [7:0] s;
        for (int r = 0; r < 4; r++) begin
            s = 8'h00;
            foreach (got2[i]) s = gf_mul(s, gf_pow(r)) ^ got2[i];
            chk($sformatf("%s_S%0d", tag, r), s, 0);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic e);
        if (sel == 0) begin
            b1.in_vld = v; b1.in_data = d; b1.in_eop = e;
        end else begin
            b2.in_vld = v; b2.in_data = d; b2.in_eop = e;
        end
    endtask

    function automatic logic rdy_of(input int sel);
        return (sel == 0) ? b1.in_rdy : b2.in_rdy;
    endfunction

    function automatic logic eop_flag(input int sel, input int idx, input int n);
`ifdef RS_ENC_SHORT_EN
        return (sel == 0) ? 1'b1 : (idx == n - 1);
`else
        return 1'($urandom_range(0, 1));
`endif
    endfunction

    task automatic send(input int sel, input int off, input int n, input bit gaps,
                        input int abort_at, output bit ok);
        int   idx;
        int   guard;
        logic v;
        idx = 0; guard = 0; ok = 1'b1;
        while (idx < n) begin
            if (abort_at >= 0 && idx == abort_at) break;
            if (guard > 8000) begin ok = 1'b0; break; end
            @(posedge clk); #2;
            v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            drive(sel, v, msg[off+idx], eop_flag(sel, idx, n));
            @(negedge clk);
            guard++;
            if (v && rdy_of(sel)) idx++;
        end
        @(posedge clk); #2;
        drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    // Waits for the expected queue to empty; only parity is left, so in_rdy must stay low.
    task automatic wait_drain(input int sel, input string tag);
        int guard;
        guard = 0;
        while (1) begin
            @(negedge clk); #1;
            if ((sel == 0 ? exp_q1.size() : exp_q2.size()) == 0) break;
            chk({tag, "_par_in_rdy"}, rdy_of(sel), 0);
            guard++;
            if (guard > 8000) begin
                chk({tag, "_drain_timeout"}, guard, 0);
                break;
            end
        end
    endtask

    task automatic clr(input int sel);
        n_out[sel] = 0; first_c[sel] = 0; last_c[sel] = 0; sop_n[sel] = 0; eop_n[sel] = 0;
        if (sel == 0) got1.delete();
        else          got2.delete();
    endtask

    // ---------------- scoreboard / monitor ----------------
    task automatic mon_step(input int s, input logic v, input logic r, input logic sp,
                            input logic ep, input logic [7:0] d);
        logic [9:0] e;
        int         qn;
        if (!rstn) begin
            prev_stall[s] = 1'b0;
            return;
        end
        if (prev_stall[s]) begin
            chk($sformatf("hold_vld%0d", s), v, 1);
            chk($sformatf("hold_data%0d", s), d, prev_d[s]);
        end
        if (v && r) begin
            qn = (s == 0) ? exp_q1.size() : exp_q2.size();
            chk($sformatf("exp_avail%0d", s), (qn > 0), 1);
            if (qn > 0) begin
                e = (s == 0) ? exp_q1.pop_front() : exp_q2.pop_front();
                chk($sformatf("cw_byte%0d_n%0d", s, n_out[s]), {sp, ep, d}, e);
            end
            if (s == 0) got1.push_back(d);
            else        got2.push_back(d);
            if (n_out[s] == 0) first_c[s] = cyc;
            last_c[s] = cyc;
            n_out[s]++;
            sop_n[s] += int'(sp);
            eop_n[s] += int'(ep);
        end
        prev_stall[s] = v && !r;
        prev_d[s]     = d;
    endtask

    always @(negedge clk) begin
        mon_step(0, b1.enc_vld, b1.enc_rdy, b1.enc_sop, b1.enc_eop, b1.enc_data);
        mon_step(1, b2.enc_vld, b2.enc_rdy, b2.enc_sop, b2.enc_eop, b2.enc_data);
    end

    initial begin
        b1.enc_rdy = 1'b1;
        b2.enc_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            b1.enc_rdy = stall[0] ? ($urandom_range(0, 3) != 0) : 1'b1;
            b2.enc_rdy = stall[1] ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        bit ok;
        stall[0] = 1'b0; stall[1] = 1'b0;
        drive(0, 1'b0, 8'h00, 1'b0);
        drive(1, 1'b0, 8'h00, 1'b0);
        make_gen();
        chk("gen_poly", {g_d[0], g_d[1], g_d[2], g_d[3], g_d[4]}, 40'h010F367840);

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_data_k1",  b1.enc_data, 8'h00);
        chk("rst_vld_k1",   b1.enc_vld, 0);
        chk("rst_sop_k1",   b1.enc_sop, 0);
        chk("rst_eop_k1",   b1.enc_eop, 0);
        chk("rst_data_k251", b2.enc_data, 8'h00);
        chk("rst_vld_k251", b2.enc_vld, 0);
        chk("rst_sop_k251", b2.enc_sop, 0);
        chk("rst_eop_k251", b2.enc_eop, 0);
        rstn = 1'b1;
        clr(0); clr(1);

        // K=1 directed: {01} and {02}, literal codewords
        msg[0] = 8'h01;
        push_cw(0, 0, 1); clr(0);
        send(0, 0, 1, 1'b0, -1, ok); chk("k1_a_send", ok, 1);
        wait_drain(0, "k1_a");
        chk("k1_a_count", n_out[0], 5);
        chk("k1_a_contig", last_c[0] - first_c[0], 4);
        chk("k1_a_bytes", {got1[0], got1[1], got1[2], got1[3], got1[4]}, 40'h010F367840);
        msg[0] = 8'h02;
        push_cw(0, 0, 1); clr(0);
        send(0, 0, 1, 1'b0, -1, ok); chk("k1_b_send", ok, 1);
        wait_drain(0, "k1_b");
        chk("k1_b_bytes", {got1[0], got1[1], got1[2], got1[3], got1[4]}, 40'h021E6CF080);
        chk("k1_b_sop_eop", {sop_n[0][7:0], eop_n[0][7:0]}, 16'h0101);

        // K=1 random frames with stalls and input gaps
        for (int i = 0; i < 16; i++) begin
            msg[i] = 8'($urandom_range(0, 255));
            push_cw(0, i, 1);
        end
        clr(0); stall[0] = 1'b1;
        send(0, 0, 16, 1'b1, -1, ok); chk("k1_rnd_send", ok, 1);
        wait_drain(0, "k1_rnd");
        chk("k1_rnd_count", n_out[0], 80);
        stall[0] = 1'b0;

        // K=251 all-zero message
        for (int i = 0; i < 251; i++) msg[i] = 8'h00;
        push_cw(1, 0, 251); clr(1);
        send(1, 0, 251, 1'b0, -1, ok); chk("zero_send", ok, 1);
        wait_drain(1, "zero");
        chk("zero_count", n_out[1], 255);
        chk("zero_contig", last_c[1] - first_c[1], 254);
        chk("zero_sop_n", sop_n[1], 1);
        chk("zero_eop_n", eop_n[1], 1);
        chk("zero_parity", {got2[251], got2[252], got2[253], got2[254]}, 32'h0);

        // K=251 random message without stalls, then the same one with stalls and gaps
        for (int i = 0; i < 251; i++) msg[i] = 8'($urandom_range(0, 255));
        push_cw(1, 0, 251); clr(1);
        send(1, 0, 251, 1'b0, -1, ok); chk("rnd_send", ok, 1);
        wait_drain(1, "rnd");
        chk("rnd_count", n_out[1], 255);
        chk("rnd_contig", last_c[1] - first_c[1], 254);
        check_syn("rnd");

        push_cw(1, 0, 251); clr(1); stall[1] = 1'b1;
        send(1, 0, 251, 1'b1, -1, ok); chk("bp_send", ok, 1);
        wait_drain(1, "bp");
        chk("bp_count", n_out[1], 255);
        check_syn("bp");
        stall[1] = 1'b0;

        // Abort at message byte 100 with reset, then a clean frame
        for (int i = 0; i < 251; i++) msg[i] = 8'($urandom_range(0, 255));
        push_cw(1, 0, 251); clr(1);
        send(1, 0, 251, 1'b0, 100, ok);
        rstn = 1'b0;
        #1;
        chk("abort_vld",  b2.enc_vld, 0);
        chk("abort_sop",  b2.enc_sop, 0);
        chk("abort_eop",  b2.enc_eop, 0);
        chk("abort_data", b2.enc_data, 8'h00);
        exp_q2.delete();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 251; i++) msg[i] = 8'($urandom_range(0, 255));
        push_cw(1, 0, 251); clr(1);
        send(1, 0, 251, 1'b0, -1, ok); chk("post_rst_send", ok, 1);
        wait_drain(1, "post_rst");
        chk("post_rst_count", n_out[1], 255);
        chk("post_rst_sop_n", sop_n[1], 1);
        check_syn("post_rst");

`ifdef RS_ENC_SHORT_EN
        msg[0] = 8'h01; msg[1] = 8'h00; msg[2] = 8'h00;
        push_cw(1, 0, 3); clr(1);
        send(1, 0, 3, 1'b0, -1, ok); chk("short3_send", ok, 1);
        wait_drain(1, "short3");
        chk("short3_count", n_out[1], 7);
        check_syn("short3");
        msg[0] = 8'($urandom_range(0, 255));
        push_cw(1, 0, 1); clr(1);
        send(1, 0, 1, 1'b0, -1, ok); chk("short1_send", ok, 1);
        wait_drain(1, "short1");
        chk("short1_count", n_out[1], 5);
        check_syn("short1");
`endif

        repeat (3) @(negedge clk);
        chk("k1_q_empty", exp_q1.size(), 0);
        chk("k251_q_empty", exp_q2.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
